// File: rtl/sm4_key_expansion_if.sv
// sm4_key_expansion_if: key request inputs and round-key bank outputs
// of the SM4 key schedule; master = requester, slave = key schedule.
interface sm4_key_expansion_if;
    logic         sm4_enable_in;
    logic         key_valid_in;
    logic [127:0] key_in;
    logic         dec_in;
    logic [31:0]  rk_00_out, rk_01_out, rk_02_out, rk_03_out;
    logic [31:0]  rk_04_out, rk_05_out, rk_06_out, rk_07_out;
    logic [31:0]  rk_08_out, rk_09_out, rk_10_out, rk_11_out;
    logic [31:0]  rk_12_out, rk_13_out, rk_14_out, rk_15_out;
    logic [31:0]  rk_16_out, rk_17_out, rk_18_out, rk_19_out;
    logic [31:0]  rk_20_out, rk_21_out, rk_22_out, rk_23_out;
    logic [31:0]  rk_24_out, rk_25_out, rk_26_out, rk_27_out;
    logic [31:0]  rk_28_out, rk_29_out, rk_30_out, rk_31_out;
    logic         key_exp_ready_out;

    modport master (
        output sm4_enable_in, key_valid_in, key_in, dec_in,
        input  rk_00_out, rk_01_out, rk_02_out, rk_03_out,
        input  rk_04_out, rk_05_out, rk_06_out, rk_07_out,
        input  rk_08_out, rk_09_out, rk_10_out, rk_11_out,
        input  rk_12_out, rk_13_out, rk_14_out, rk_15_out,
        input  rk_16_out, rk_17_out, rk_18_out, rk_19_out,
        input  rk_20_out, rk_21_out, rk_22_out, rk_23_out,
        input  rk_24_out, rk_25_out, rk_26_out, rk_27_out,
        input  rk_28_out, rk_29_out, rk_30_out, rk_31_out,
        input  key_exp_ready_out
    );

    modport slave (
        input  sm4_enable_in, key_valid_in, key_in, dec_in,
        output rk_00_out, rk_01_out, rk_02_out, rk_03_out,
        output rk_04_out, rk_05_out, rk_06_out, rk_07_out,
        output rk_08_out, rk_09_out, rk_10_out, rk_11_out,
        output rk_12_out, rk_13_out, rk_14_out, rk_15_out,
        output rk_16_out, rk_17_out, rk_18_out, rk_19_out,
        output rk_20_out, rk_21_out, rk_22_out, rk_23_out,
        output rk_24_out, rk_25_out, rk_26_out, rk_27_out,
        output rk_28_out, rk_29_out, rk_30_out, rk_31_out,
        output key_exp_ready_out
    );
endinterface

// File: rtl/sm4_key_expansion.sv
// sm4_key_expansion: iterative SM4 key schedule, one round per clock.
// Define SM4_KEY_DEC_EN to honour dec_in (reversed, decryption slot order).
module sm4_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] TBL = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // entry 0 sits in the top byte, so entry a starts at 8*(255-a)
    logic [10:0] pos;
    assign pos = {~a, 3'b000};
    assign y   = TBL[pos +: 8];
endmodule

module sm4_key_expansion (
    input logic                clk,
    input logic                reset_n,
    sm4_key_expansion_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;

    state_t      state;
    logic [31:0] win [4];
    logic [4:0]  cnt;
    logic        ready;
    logic [31:0] bank [32];

    logic [31:0] ck;
    logic [31:0] mix;
    logic [31:0] sub;
    logic [31:0] lin;
    logic [31:0] nxt;
    logic [4:0]  widx;
    logic        accept;

    for (genvar j = 0; j < 4; j++) begin : g_byte
        logic [7:0] idx;
        assign idx = {1'b0, cnt, 2'(j)};
        assign ck[31-8*j -: 8] = idx * 8'd7;
        sm4_sbox u_sbox (
            .a (mix[31-8*j -: 8]),
            .y (sub[31-8*j -: 8])
        );
    end

    assign mix = win[1] ^ win[2] ^ win[3] ^ ck;
    assign lin = sub
               ^ {sub[18:0], sub[31:19]}
               ^ {sub[8:0],  sub[31:9]};
    assign nxt = win[0] ^ lin;

    assign accept = bus.sm4_enable_in
                  & bus.key_valid_in
                  & (state != EXPAND);

`ifdef SM4_KEY_DEC_EN
    logic dec_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_q <= 1'b0;
        end else if (accept) begin
            dec_q <= bus.dec_in;
        end
    end

    // 31 - cnt in five bits is the bitwise complement
    assign widx = dec_q ? ~cnt : cnt;
`else
    assign widx = cnt;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                win[i] <= '0;
            end
            for (int i = 0; i < 32; i++) begin
                bank[i] <= '0;
            end
        end else if (!bus.sm4_enable_in) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.key_valid_in) begin
                        state  <= EXPAND;
                        cnt    <= '0;
                        ready  <= 1'b0;
                        win[0] <= bus.key_in[127:96] ^ FK0;
                        win[1] <= bus.key_in[95:64]  ^ FK1;
                        win[2] <= bus.key_in[63:32]  ^ FK2;
                        win[3] <= bus.key_in[31:0]   ^ FK3;
                    end
                end
                EXPAND: begin
                    bank[widx] <= nxt;
                    win[0]     <= win[1];
                    win[1]     <= win[2];
                    win[2]     <= win[3];
                    win[3]     <= nxt;
                    cnt        <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= DONE;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.key_exp_ready_out = ready;

    assign bus.rk_00_out = bank[0];
    assign bus.rk_01_out = bank[1];
    assign bus.rk_02_out = bank[2];
    assign bus.rk_03_out = bank[3];
    assign bus.rk_04_out = bank[4];
    assign bus.rk_05_out = bank[5];
    assign bus.rk_06_out = bank[6];
    assign bus.rk_07_out = bank[7];
    assign bus.rk_08_out = bank[8];
    assign bus.rk_09_out = bank[9];
    assign bus.rk_10_out = bank[10];
    assign bus.rk_11_out = bank[11];
    assign bus.rk_12_out = bank[12];
    assign bus.rk_13_out = bank[13];
    assign bus.rk_14_out = bank[14];
    assign bus.rk_15_out = bank[15];
    assign bus.rk_16_out = bank[16];
    assign bus.rk_17_out = bank[17];
    assign bus.rk_18_out = bank[18];
    assign bus.rk_19_out = bank[19];
    assign bus.rk_20_out = bank[20];
    assign bus.rk_21_out = bank[21];
    assign bus.rk_22_out = bank[22];
    assign bus.rk_23_out = bank[23];
    assign bus.rk_24_out = bank[24];
    assign bus.rk_25_out = bank[25];
    assign bus.rk_26_out = bank[26];
    assign bus.rk_27_out = bank[27];
    assign bus.rk_28_out = bank[28];
    assign bus.rk_29_out = bank[29];
    assign bus.rk_30_out = bank[30];
    assign bus.rk_31_out = bank[31];
endmodule

// File: doc/sm4_key_expansion.md
# sm4_key_expansion

Iterative SM4 (GB/T 32907) key schedule feeding the SM4 encrypt/decrypt datapath. Takes a 128-bit master key, computes the 32 round keys at one round per clock, and presents them as 32 parallel, stable 32-bit buses with a ready flag. The downstream datapath waits on that flag before it starts processing blocks.

## Interface
- Parameters: none. Widths and round count are fixed by the SM4 standard.
- clk  input  1  rising-edge clock
- reset_n  input  1  reset, asynchronous, active-low
- sm4_enable_in  input  1  block enable; low forces IDLE
- key_valid_in  input  1  master key present on key_in this cycle
- key_in  input  128  master key MK, MK0 in bits [127:96]
- dec_in  input  1  0 = encryption key order, 1 = decryption (reversed) order
- rk_00_out … rk_31_out  output  32 each  round keys in datapath consumption order
- key_exp_ready_out  output  1  all 32 round keys valid and stable

## Operation
- Setup when a key is accepted: K0..K3 = MK0..MK3 XOR FK0..FK3.
  - FK0..FK3 = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
- Round i (i = 0..31): rk_i = K(i+4) = K(i) XOR T'(K(i+1) XOR K(i+2) XOR K(i+3) XOR CK_i).
  - T' is the byte-wise S-box τ followed by L'(B) = B XOR (B<<<13) XOR (B<<<23).
  - The S-box is the shared 8-bit SM4 S-box, 4 instances, combinational.
- CK_i is generated arithmetically, not stored in a table.
  - Byte j of CK_i (j = 0 is the MSB) = ((4i + j) × 7) mod 256.
  - Use 8-bit wrap-around arithmetic.
- State: a 4×32 sliding window {K(i)..K(i+3)} and a 5-bit round counter cnt.
  - Each round shifts the window left by one word and appends the new word.
- Round-key bank write index:
  - dec latched 0: rk_i is written to slot cnt.
  - dec latched 1: rk_i is written to slot 31−cnt.
- dec_in is latched only when a key is accepted. Changes at any other time are ignored.
- FSM states: IDLE, EXPAND, DONE.
  - IDLE → EXPAND: sm4_enable_in and key_valid_in both high. Load the window, set cnt = 0, latch dec_in.
  - EXPAND: one round per cycle, cnt increments. When cnt = 31 is written, go to DONE. cnt wraps to 0.
  - DONE → EXPAND: key_valid_in high (rekey). The new key is loaded as above.
  - Any state → IDLE: sm4_enable_in low.
- key_valid_in during EXPAND is ignored. The current expansion completes with the original key.
- Abort (sm4_enable_in low mid-EXPAND):
  - cnt clears and ready stays 0.
  - Partially written rk slots keep their values and are not valid.

## Timing
- Reset values: all rk_*_out = 32'h0, key_exp_ready_out = 0, state IDLE, cnt = 0, window = 0.
- Reset asserted mid-operation clears all of the above immediately, regardless of clock.
- Latency: key accepted on edge E.
  - Round keys are written on edges E+1 through E+32.
  - key_exp_ready_out rises on edge E+32, i.e. together with the last slot write.
- key_exp_ready_out:
  - Registered. Stays high while in DONE.
  - Falls on the edge that accepts a rekey, or the edge after sm4_enable_in drops.
- rk_*_out are registered and do not change while key_exp_ready_out is high.
- Throughput: one new key per 33 cycles. Rekey is accepted in the cycle immediately after DONE is entered.

## Configuration
- Macro: SM4_KEY_DEC_EN.
- Defined: dec_in is honoured and reversed slot order is available.
- Undefined:
  - dec_in is unconnected internally, always treated as 0.
  - The reverse-index mux is not built; keys are always in encryption order.

## Test plan
- Standard vector, encryption: MK = 0123456789ABCDEFFEDCBA9876543210, dec_in = 0.
  - Expect rk_00 = F12186F9, rk_31 = 9124A012.
  - Expect ready high exactly 32 cycles after the accepting edge.
- Same MK with dec_in = 1 (SM4_KEY_DEC_EN defined):
  - Expect rk_00 = 9124A012, rk_31 = F12186F9, and every slot k equals the encryption slot 31−k.
- key_valid_in pulsed again at cycle 10 of EXPAND with a different key:
  - The pulse is ignored; results equal the first vector; ready timing is unchanged.
- Rekey in DONE with MK = 0: ready drops on the accepting edge and rises again 32 cycles later.
  - rk_00 must equal the standard value recomputed from K = FK.
- sm4_enable_in dropped at cycle 15 of EXPAND:
  - IDLE next cycle, ready stays 0.
  - A new key accepted afterwards expands fully and matches the reference model.
- reset_n asserted asynchronously mid-EXPAND:
  - All outputs read 0 before the next clock edge; after release, state is IDLE.
